// File: rtl/pulse_meas.sv
// -----------------------------------------------------------------------------
// pulse_meas
//
// Measures an incoming pulse train in clk cycles. It reports the rise-to-rise
// period and the rise-to-fall high time. It also flags an input stuck HIGH or
// stuck LOW. Typical uses are loopback self-test of pulse_gen and external PWM
// capture.
//
// Build option: define PULSE_MEAS_DEGLITCH_EN to insert a 3-sample agreement
// filter after the synchronizer. With the filter, phases shorter than 3 cycles
// are ignored, and two edges of latency are added. Without it, every 1-cycle
// phase is measured.
//
// Parameters
//   CNTR_WIDTH  width of the cycle counter and of the period/high_time results
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   en          measurement enable; 0 forces IDLE and clears the flags
//   sig_in      asynchronous pulse input (synchronized internally)
//   period      last measured rise-to-rise distance, cycles
//   high_time   last measured rise-to-fall distance, cycles
//   meas_valid  one-cycle strobe; period/high_time updated this cycle
//   const_high  input held HIGH until the counter saturated with no edge
//   const_low   input held LOW until the counter saturated with no edge
//   busy        reference rise captured (HIGH_PH or LOW_PH)
// -----------------------------------------------------------------------------
module pulse_meas #(
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sig_in,
    output logic [CNTR_WIDTH-1:0] period,
    output logic [CNTR_WIDTH-1:0] high_time,
    output logic                  meas_valid,
    output logic                  const_high,
    output logic                  const_low,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HIGH_PH = 2'd1;
    localparam logic [1:0] ST_LOW_PH  = 2'd2;

    localparam logic [CNTR_WIDTH-1:0] SAT = '1;
    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

    // Saturating increment: the counter never wraps, it sticks at SAT.
    function automatic logic [CNTR_WIDTH-1:0] sat_inc(input logic [CNTR_WIDTH-1:0] v);
        return (v == SAT) ? SAT : v + ONE;
    endfunction

    // ---- stage: two-flop synchronizer ----
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ---- stage: optional deglitch filter, produces level s and its delayed copy ----
    logic s;
    logic s_d1;

`ifdef PULSE_MEAS_DEGLITCH_EN
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;
    logic filt_q, filt_d;

    // The filtered level follows the synchronized input only when the current
    // sample and the two before it agree. filt_q holds the previous filtered
    // level, so it also serves as s delayed by one cycle. Because the delay
    // is uniform for both edges, accepted phases keep their width.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        s       = ((sync2_q == hist1_q) && (hist1_q == hist2_q)) ? sync2_q : filt_q;
        filt_d  = s;
        s_d1    = filt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end
`else
    logic s_d1_q, s_d1_d;

    always_comb begin
        s      = sync2_q;
        s_d1_d = s;
        s_d1   = s_d1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d1_q <= 1'b0;
        end else begin
            s_d1_q <= s_d1_d;
        end
    end
`endif

    // ---- stage: edge detection, counter, FSM and result registers ----
    logic rise;
    logic fall;
    logic any_edge;

    logic [1:0]            state_q, state_d;
    logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
    logic [CNTR_WIDTH-1:0] high_buf_q, high_buf_d;
    logic [CNTR_WIDTH-1:0] period_q, period_d;
    logic [CNTR_WIDTH-1:0] high_time_q, high_time_d;
    logic                  meas_valid_q, meas_valid_d;
    logic                  const_high_q, const_high_d;
    logic                  const_low_q, const_low_d;

    always_comb begin
        rise     = s & ~s_d1;
        fall     = ~s & s_d1;
        any_edge = rise | fall;

        state_d      = state_q;
        cntr_d       = cntr_q;
        high_buf_d   = high_buf_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        const_high_d = const_high_q;
        const_low_d  = const_low_q;

        if (!en) begin
            state_d      = ST_IDLE;
            cntr_d       = '0;
            const_high_d = 1'b0;
            const_low_d  = 1'b0;
        end else if (!any_edge && (cntr_q == SAT)) begin
            // No edge for a full counter span: drop any partial measurement
            // and report the level the input is stuck at.
            state_d      = ST_IDLE;
            const_high_d = s;
            const_low_d  = ~s;
        end else begin
            // A rise always opens a new reference. A fall restarts the count
            // only while idle. Inside a measurement, the count keeps running
            // through the fall, so the value at the next rise is the full
            // rise-to-rise period. It also means an overlong LOW phase after a
            // measured HIGH phase saturates and raises const_low.
            if (rise || (fall && (state_q == ST_IDLE))) begin
                cntr_d = ONE;
            end else begin
                cntr_d = sat_inc(cntr_q);
            end

            if (any_edge) begin
                const_high_d = 1'b0;
                const_low_d  = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HIGH_PH;
                    end
                end
                ST_HIGH_PH: begin
                    if (fall) begin
                        state_d    = ST_LOW_PH;
                        high_buf_d = cntr_q;
                    end
                end
                ST_LOW_PH: begin
                    if (rise) begin
                        state_d = ST_HIGH_PH;
                        // A period that reached SAT is not representable as a result.
                        if (cntr_q != SAT) begin
                            period_d     = cntr_q;
                            high_time_d  = high_buf_q;
                            meas_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cntr_q       <= '0;
            high_buf_q   <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            const_high_q <= 1'b0;
            const_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cntr_q       <= cntr_d;
            high_buf_q   <= high_buf_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            const_high_q <= const_high_d;
            const_low_q  <= const_low_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign const_high = const_high_q;
    assign const_low  = const_low_q;
    assign busy       = (state_q == ST_HIGH_PH) || (state_q == ST_LOW_PH);

endmodule

// File: tb/tb_pulse_meas.sv
// -----------------------------------------------------------------------------
// tb_pulse_meas
//
// Directed scoreboard bench for pulse_meas with CNTR_WIDTH = 4 (SAT = 15).
// The stimulus pushes the expected {period, high_time} before it drives the
// rise that completes each measurement. A monitor pops one entry from the
// queue and compares it on every meas_valid strobe. Flag, busy and reset
// checks are made directly at negedges.
// -----------------------------------------------------------------------------
module tb_pulse_meas;

    localparam int W = 4;
`ifdef PULSE_MEAS_DEGLITCH_EN
    localparam int XL = 2;
`else
    localparam int XL = 0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         const_high;
    logic         const_low;
    logic         busy;

    pulse_meas #(.CNTR_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .const_high (const_high),
        .const_low  (const_low),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic push(input int p, input int h);
        exp_t e;
        e.p = p;
        e.h = h;
        exp_q.push_back(e);
    endtask

    // Drive a level for n full clock cycles (changes happen at negedges).
    task automatic hold(input logic lvl, input int n);
        sig_in = lvl;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic restart_en();
        en = 1'b0;
        hold(1'b0, 3);
        en = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: period=%0d high_time=%0d, no strobe required",
                         period, high_time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_period", 32'(period), e.p);
                check("strobe_high_time", 32'(high_time), e.h);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        #12;
        check("rst_period", 32'(period), 0);
        check("rst_high_time", 32'(high_time), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_const_high", 32'(const_high), 0);
        check("rst_const_low", 32'(const_low), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // High 3 / low 5 repeating: period 8, high_time 3 from the second rise.
        hold(1'b0, 4);
        hold(1'b1, 3);
        hold(1'b0, 5);
        check("s1_busy", 32'(busy), 1);
        repeat (3) begin
            push(8, 3);
            hold(1'b1, 3);
            hold(1'b0, 5);
        end
        push(8, 3);
        hold(1'b1, 3);
        hold(1'b0, 4);
        en = 1'b0;
        hold(1'b0, 3);
        check("s1_en0_busy", 32'(busy), 0);
        check("s1_en0_period_hold", 32'(period), 8);
        check("s1_en0_high_hold", 32'(high_time), 3);
        en = 1'b1;

        // Loopback shape of pulse_gen cntr_max=9, cntr_low=4: high 6 / low 4.
        hold(1'b0, 4);
        hold(1'b1, 6);
        hold(1'b0, 4);
        repeat (3) begin
            push(10, 6);
            hold(1'b1, 6);
            hold(1'b0, 4);
        end
        push(10, 6);
        hold(1'b1, 6);
        check("s2_const_high", 32'(const_high), 0);
        check("s2_const_low", 32'(const_low), 0);
        hold(1'b0, 4);
        restart_en();

        // Stuck HIGH after one rise: const_high once cntr reaches 15.
        hold(1'b0, 4);
        hold(1'b1, 16);
        check("s3_const_high_early", 32'(const_high), 0);
        hold(1'b1, 6);
        check("s3_const_high", 32'(const_high), 1);
        check("s3_const_low", 32'(const_low), 0);
        check("s3_busy", 32'(busy), 0);
        hold(1'b0, 5);
        check("s3_const_high_clear", 32'(const_high), 0);
        check("s3_const_low_clear", 32'(const_low), 0);

        // High 3 / low 14 saturates in LOW_PH: const_low, no strobe, old result kept.
        hold(1'b1, 3);
        hold(1'b0, 5);
        push(8, 3);
        hold(1'b1, 3);
        hold(1'b0, 14);
        sig_in = 1'b1;
        repeat (1 + XL) @(negedge clk);
        check("s4_const_low", 32'(const_low), 1);
        check("s4_const_high", 32'(const_high), 0);
        check("s4_busy", 32'(busy), 0);
        check("s4_period_kept", 32'(period), 8);
        check("s4_high_kept", 32'(high_time), 3);
        hold(1'b1, 2 - XL);
        hold(1'b0, 5);
        push(8, 3);
        hold(1'b1, 3);
        hold(1'b0, 4);
        check("s4_const_low_clear", 32'(const_low), 0);
        restart_en();

        // Reset while in LOW_PH: immediate clear, then rise/fall/rise needed.
        hold(1'b0, 4);
        hold(1'b1, 4);
        hold(1'b0, 4);
        push(8, 4);
        hold(1'b1, 4);
        hold(1'b0, 5);
        #2;
        rst = 1'b1;
        #1;
        check("s5_rst_period", 32'(period), 0);
        check("s5_rst_high_time", 32'(high_time), 0);
        check("s5_rst_busy", 32'(busy), 0);
        check("s5_rst_meas_valid", 32'(meas_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 3);
        hold(1'b1, 4);
        hold(1'b0, 4);
        push(8, 4);
        hold(1'b1, 4);
        hold(1'b0, 4);
        restart_en();

        // 4/4 train with a 1-cycle HIGH glitch inside one LOW phase.
        hold(1'b0, 4);
        hold(1'b1, 4);
        hold(1'b0, 4);
        push(8, 4);
        hold(1'b1, 4);
        hold(1'b0, 4);
        push(8, 4);
        hold(1'b1, 4);
        hold(1'b0, 3);
`ifndef PULSE_MEAS_DEGLITCH_EN
        push(7, 4);
`endif
        hold(1'b1, 1);
        hold(1'b0, 4);
`ifdef PULSE_MEAS_DEGLITCH_EN
        push(12, 4);
`else
        push(5, 1);
`endif
        hold(1'b1, 4);
        hold(1'b0, 4);
        push(8, 4);
        hold(1'b1, 4);
        hold(1'b0, 10);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
